// File: rtl/mem_host_pkg.sv
// rtl/mem_host_pkg.sv - shared opcodes, FSM encoding and width defaults for the memory host port
package mem_host_pkg;

   localparam int ADDR_W_DEF  = 13;
   localparam int EADDR_W_DEF = 9;
   localparam int DATA_W      = 32;
   localparam int PIN_W       = 7;
   localparam int LEN_W       = 8;

   typedef enum logic [2:0] {
      OP_READ       = 3'd0,
      OP_WRITE      = 3'd1,
      OP_FILL       = 3'd2,
      OP_INJ_DATA   = 3'd3,
      OP_INJ_PARITY = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR       = 3'd1,
      ST_FILL     = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RD_RSP   = 3'd5,
      ST_INJ      = 3'd6
   } state_e;

endpackage

// File: rtl/mem_host_rd_pipe.sv
// rtl/mem_host_rd_pipe.sv - read latency counter and held response register with valid/ready
module mem_host_rd_pipe
   import mem_host_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_i,
   input  logic              wait_i,
   input  logic              last_i,
   input  logic [DATA_W-1:0] dout_i,
   input  logic              rsp_ready_i,
   output logic              capture_o,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_last_o
);

   localparam int LAT_W = 3;

   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;

   // user_dout is valid in the READ_LAT-th wait cycle after the address was issued
   assign capture_o = wait_i && (lat_q == LAT_W'(READ_LAT - 1));

   always_comb begin
      lat_d   = lat_q;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (issue_i) begin
         lat_d = '0;
      end else if (wait_i) begin
         lat_d = lat_q + LAT_W'(1);
      end
      if (capture_o) begin
         valid_d = 1'b1;
         data_d  = dout_i;
         last_d  = last_i;
      end else if (valid_q && rsp_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         lat_q   <= lat_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign rsp_valid_o = valid_q;
   assign rsp_data_o  = data_q;
   assign rsp_last_o  = valid_q & last_q;

endmodule

// File: rtl/mem_host_port.sv
// rtl/mem_host_port.sv - command-driven master for the core user memory port and EDC injection port
module mem_host_port
   import mem_host_pkg::*;
#(
   parameter int READ_LAT = 1,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int EADDR_W  = EADDR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic [DATA_W-1:0]  cmd_data,
   input  logic [LEN_W-1:0]   cmd_len,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_last,
   output logic               cmd_err,
   output logic               busy,
   output logic [ADDR_W-1:0]  user_addr,
   output logic               user_we,
   output logic [DATA_W-1:0]  user_din,
   input  logic [DATA_W-1:0]  user_dout,
   output logic               error_dwe,
   output logic               error_pwe,
   output logic [DATA_W-1:0]  error_din,
   output logic [PIN_W-1:0]   error_pin,
   output logic [EADDR_W-1:0] error_addr
);

   state_e             state_q, state_d;
   logic               ready_q;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  uaddr_q, uaddr_d;
   logic               uwe_q, uwe_d;
   logic [DATA_W-1:0]  udin_q, udin_d;
   logic               dwe_q, dwe_d;
   logic               pwe_q, pwe_d;
   logic [DATA_W-1:0]  edin_q, edin_d;
   logic [PIN_W-1:0]   epin_q, epin_d;
   logic [EADDR_W-1:0] eaddr_q, eaddr_d;
   logic               err_q, err_d;
   logic               accept;
   logic               capture;
   logic               rsp_fire;

   // ready_q keeps cmd_ready low during reset and for the first cycle after release
   assign busy      = (state_q != ST_IDLE);
   assign cmd_ready = ready_q & ~busy;
   assign accept    = cmd_valid & cmd_ready;
   assign rsp_fire  = rsp_valid & rsp_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      uaddr_d = uaddr_q;
      uwe_d   = 1'b0;
      udin_d  = udin_q;
      dwe_d   = 1'b0;
      pwe_d   = 1'b0;
      edin_d  = edin_q;
      epin_d  = epin_q;
      eaddr_d = eaddr_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = cmd_len;
               case (cmd_op)
                  OP_READ: begin
                     state_d = ST_RD_ISSUE;
                     uaddr_d = cmd_addr;
                  end
                  OP_WRITE, OP_FILL: begin
                     state_d = (cmd_op == OP_WRITE) ? ST_WR : ST_FILL;
                     uwe_d   = 1'b1;
                     uaddr_d = cmd_addr;
                     udin_d  = cmd_data;
                  end
                  OP_INJ_DATA: begin
                     state_d = ST_INJ;
                     dwe_d   = 1'b1;
                     eaddr_d = cmd_addr[EADDR_W-1:0];
                     edin_d  = cmd_data;
                  end
                  OP_INJ_PARITY: begin
                     state_d = ST_INJ;
                     pwe_d   = 1'b1;
                     eaddr_d = cmd_addr[EADDR_W-1:0];
                     epin_d  = cmd_data[PIN_W-1:0];
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_WR: state_d = ST_IDLE;
         ST_FILL: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q - LEN_W'(1);
               uwe_d   = 1'b1;
               uaddr_d = uaddr_q + ADDR_W'(1);
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (capture) state_d = ST_RD_RSP;
         end
         ST_RD_RSP: begin
            if (rsp_fire) begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RD_ISSUE;
                  cnt_d   = cnt_q - LEN_W'(1);
                  uaddr_d = uaddr_q + ADDR_W'(1);
               end
            end
         end
         ST_INJ: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         uaddr_q <= '0;
         uwe_q   <= 1'b0;
         udin_q  <= '0;
         dwe_q   <= 1'b0;
         pwe_q   <= 1'b0;
         edin_q  <= '0;
         epin_q  <= '0;
         eaddr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
         cnt_q   <= cnt_d;
         uaddr_q <= uaddr_d;
         uwe_q   <= uwe_d;
         udin_q  <= udin_d;
         dwe_q   <= dwe_d;
         pwe_q   <= pwe_d;
         edin_q  <= edin_d;
         epin_q  <= epin_d;
         eaddr_q <= eaddr_d;
         err_q   <= err_d;
      end
   end

   mem_host_rd_pipe #(
      .READ_LAT (READ_LAT)
   ) u_rd_pipe (
      .clk         (clk),
      .rst         (rst),
      .issue_i     (state_q == ST_RD_ISSUE),
      .wait_i      (state_q == ST_RD_WAIT),
      .last_i      (cnt_q == '0),
      .dout_i      (user_dout),
      .rsp_ready_i (rsp_ready),
      .capture_o   (capture),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .rsp_last_o  (rsp_last)
   );

   assign user_addr  = uaddr_q;
   assign user_we    = uwe_q;
   assign user_din   = udin_q;
   assign error_dwe  = dwe_q;
   assign error_pwe  = pwe_q;
   assign error_din  = edin_q;
   assign error_pin  = epin_q;
   assign error_addr = eaddr_q;
   assign cmd_err    = err_q;

endmodule

// File: tb/tb_mem_host_port.sv
// tb/tb_mem_host_port.sv - directed bench for mem_host_port against a two-cycle-latency memory model
module tb_mem_host_port;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [12:0] cmd_addr;
   logic [31:0] cmd_data;
   logic [7:0]  cmd_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        cmd_err;
   logic        busy;
   logic [12:0] user_addr;
   logic        user_we;
   logic [31:0] user_din;
   logic [31:0] user_dout;
   logic        error_dwe;
   logic        error_pwe;
   logic [31:0] error_din;
   logic [6:0]  error_pin;
   logic [8:0]  error_addr;

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   int dwe_cnt = 0;
   int pwe_cnt = 0;
   int overlap_cnt = 0;
   int base;
   logic [31:0] got_d[$];
   logic        got_l[$];

   logic [31:0] mem [0:8191];
   logic [31:0] dout_p1;

   mem_host_port #(.READ_LAT(LAT), .ADDR_W(13), .EADDR_W(9)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .cmd_err(cmd_err), .busy(busy),
      .user_addr(user_addr), .user_we(user_we), .user_din(user_din),
      .user_dout(user_dout), .error_dwe(error_dwe), .error_pwe(error_pwe),
      .error_din(error_din), .error_pin(error_pin), .error_addr(error_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (user_we) mem[user_addr] <= user_din;
      dout_p1   <= mem[user_addr];
      user_dout <= dout_p1;
   end

   always @(negedge clk) begin
      if (user_we) we_cnt++;
      if (error_dwe) dwe_cnt++;
      if (error_pwe) pwe_cnt++;
      if (error_dwe && error_pwe) overlap_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [12:0] addr,
                       input logic [31:0] data, input logic [7:0] len);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_len   = len;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input int nw);
      int n = 0;
      got_d.delete();
      got_l.delete();
      while (got_d.size() < nw && n < 200) begin
         if (rsp_valid && rsp_ready) begin
            got_d.push_back(rsp_data);
            got_l.push_back(rsp_last);
         end
         tick();
         n++;
      end
      chk("collect_count", 32'(got_d.size()), 32'(nw));
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
      tick(); tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_user_we", 32'(user_we), 32'd0);
      chk("rst_user_addr", 32'(user_addr), 32'd0);
      chk("rst_cmd_err", 32'(cmd_err), 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_ready_same_cycle", 32'(cmd_ready), 32'd0);
      tick();
      chk("rel_ready_next_cycle", 32'(cmd_ready), 32'd1);

      // WRITE then single-word READ
      send(3'd1, 13'h0010, 32'hDEADBEEF, 8'd0);
      chk("wr_we", 32'(user_we), 32'd1);
      chk("wr_addr", 32'(user_addr), 32'h10);
      chk("wr_din", user_din, 32'hDEADBEEF);
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      chk("wr_we_off", 32'(user_we), 32'd0);
      chk("wr_we_count", 32'(we_cnt), 32'd1);
      rsp_ready = 1'b1;
      send(3'd0, 13'h0010, 32'h0, 8'd0);
      chk("rd1_addr", 32'(user_addr), 32'h10);
      chk("rd1_valid_c1", 32'(rsp_valid), 32'd0);
      tick();
      tick();
      chk("rd1_valid_c3", 32'(rsp_valid), 32'd0);
      tick();
      chk("rd1_valid_c4", 32'(rsp_valid), 32'd1);
      chk("rd1_data", rsp_data, 32'hDEADBEEF);
      chk("rd1_last", 32'(rsp_last), 32'd1);
      tick();
      chk("rd1_valid_done", 32'(rsp_valid), 32'd0);
      chk("rd1_idle_ready", 32'(cmd_ready), 32'd1);
      chk("rd1_we_count", 32'(we_cnt), 32'd1);

      // FILL across the 13-bit wrap, then read it back
      send(3'd2, 13'h1FFE, 32'hA5A5A5A5, 8'd3);
      chk("fill_we0", 32'(user_we), 32'd1);
      chk("fill_addr0", 32'(user_addr), 32'h1FFE);
      tick();
      chk("fill_we1", 32'(user_we), 32'd1);
      chk("fill_addr1", 32'(user_addr), 32'h1FFF);
      tick();
      chk("fill_we2", 32'(user_we), 32'd1);
      chk("fill_addr2", 32'(user_addr), 32'h0000);
      tick();
      chk("fill_we3", 32'(user_we), 32'd1);
      chk("fill_addr3", 32'(user_addr), 32'h0001);
      tick();
      chk("fill_we_end", 32'(user_we), 32'd0);
      chk("fill_busy_end", 32'(busy), 32'd0);
      chk("fill_we_count", 32'(we_cnt), 32'd5);
      send(3'd0, 13'h1FFE, 32'h0, 8'd3);
      collect(4);
      for (int i = 0; i < got_d.size(); i++) begin
         chk($sformatf("fillrd_data%0d", i), got_d[i], 32'hA5A5A5A5);
         chk($sformatf("fillrd_last%0d", i), 32'(got_l[i]), (i == 3) ? 32'd1 : 32'd0);
      end
      chk("fillrd_idle", 32'(cmd_ready), 32'd1);

      // READ burst with backpressure on the first word
      send(3'd1, 13'h0100, 32'h11111111, 8'd0);
      send(3'd1, 13'h0101, 32'h22222222, 8'd0);
      send(3'd1, 13'h0102, 32'h33333333, 8'd0);
      rsp_ready = 1'b0;
      send(3'd0, 13'h0100, 32'h0, 8'd2);
      for (int n = 0; n < 20 && !rsp_valid; n++) tick();
      chk("bp_valid_seen", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp_data%0d", i), rsp_data, 32'h11111111);
         chk($sformatf("bp_last%0d", i), 32'(rsp_last), 32'd0);
         chk($sformatf("bp_addr%0d", i), 32'(user_addr), 32'h0100);
         chk($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      collect(3);
      for (int i = 0; i < got_d.size(); i++) begin
         chk($sformatf("bp_word%0d", i), got_d[i], 32'h11111111 * (i + 1));
         chk($sformatf("bp_wlast%0d", i), 32'(got_l[i]), (i == 2) ? 32'd1 : 32'd0);
      end

      // EDC injection
      send(3'd3, 13'h01FF, 32'h00000001, 8'd0);
      chk("inj_dwe", 32'(error_dwe), 32'd1);
      chk("inj_d_pwe", 32'(error_pwe), 32'd0);
      chk("inj_d_addr", 32'(error_addr), 32'h1FF);
      chk("inj_d_din", error_din, 32'h1);
      tick();
      chk("inj_dwe_off", 32'(error_dwe), 32'd0);
      send(3'd4, 13'h0003, 32'h0000007F, 8'd0);
      chk("inj_pwe", 32'(error_pwe), 32'd1);
      chk("inj_p_dwe", 32'(error_dwe), 32'd0);
      chk("inj_p_addr", 32'(error_addr), 32'h003);
      chk("inj_p_pin", 32'(error_pin), 32'h7F);
      tick();
      chk("inj_pwe_off", 32'(error_pwe), 32'd0);
      chk("inj_din_hold", error_din, 32'h1);
      chk("inj_dwe_count", 32'(dwe_cnt), 32'd1);
      chk("inj_pwe_count", 32'(pwe_cnt), 32'd1);
      chk("inj_overlap", 32'(overlap_cnt), 32'd0);

      // Illegal opcode
      base = we_cnt;
      send(3'd6, 13'h0005, 32'h12345678, 8'd0);
      chk("ill_err", 32'(cmd_err), 32'd1);
      chk("ill_busy", 32'(busy), 32'd0);
      chk("ill_we", 32'(user_we), 32'd0);
      tick();
      chk("ill_err_off", 32'(cmd_err), 32'd0);
      chk("ill_we_count", 32'(we_cnt), 32'(base));
      chk("ill_dwe_count", 32'(dwe_cnt), 32'd1);
      chk("ill_pwe_count", 32'(pwe_cnt), 32'd1);

      // Reset in the middle of a FILL
      base = we_cnt;
      send(3'd2, 13'h0200, 32'h0000005A, 8'd7);
      tick();
      chk("rf_we_before", 32'(user_we), 32'd1);
      chk("rf_addr_before", 32'(user_addr), 32'h0201);
      rst = 1'b0;
      #1;
      chk("rf_we_async", 32'(user_we), 32'd0);
      chk("rf_addr_async", 32'(user_addr), 32'd0);
      chk("rf_din_async", user_din, 32'd0);
      chk("rf_busy_async", 32'(busy), 32'd0);
      chk("rf_ready_async", 32'(cmd_ready), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rf_ready_rel", 32'(cmd_ready), 32'd0);
      tick();
      chk("rf_ready_next", 32'(cmd_ready), 32'd1);
      tick();
      tick();
      chk("rf_we_count", 32'(we_cnt), 32'(base + 2));
      chk("rf_we_idle", 32'(user_we), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
